// File: rtl/mc_main_ctrl_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional bne support is enabled by defining MC_CTRL_BNE_EN.
module mc_main_ctrl_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               iord,
  output logic               irwrite,
  output logic               memwrite,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11,
    StBne     = 4'd12,
    StRsvd13  = 4'd13,
    StRsvd14  = 4'd14,
    StRsvd15  = 4'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OpBne   = 6'b000101;
`endif

  state_e state_q, state_d;
  logic   illegal_int;
  logic   pcwrite_int;
  logic   branch_int;
  logic   bne_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mem_ready only matters in the three memory-access states.
  always_comb begin
    state_d     = state_q;
    illegal_int = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
`ifdef MC_CTRL_BNE_EN
          OpBne:      state_d = StBne;
`endif
          default: begin
            state_d     = StFetch;
            illegal_int = 1'b1;
          end
        endcase
      end
      StMemAdr: state_d = (op == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: state_d = StFetch;
      StMemWr: begin
        if (mem_ready) state_d = StFetch;
      end
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StJump:   state_d = StFetch;
`ifdef MC_CTRL_BNE_EN
      StBne:    state_d = StFetch;
`endif
      default:  state_d = StFetch;
    endcase
  end

  // Moore decode; reset forces every output low even though state already reads FETCH.
  always_comb begin
    iord        = 1'b0;
    irwrite     = 1'b0;
    memwrite    = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsrc       = 2'b00;
    pcwrite_int = 1'b0;
    branch_int  = 1'b0;
    bne_int     = 1'b0;
    case (state_q)
      StFetch: begin
        alusrcb     = 2'b01;
        irwrite     = mem_ready;
        pcwrite_int = mem_ready;
      end
      StDecode: begin
        alusrcb = 2'b11;
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: begin
        iord = 1'b1;
      end
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      StMemWr: begin
        iord     = 1'b1;
        memwrite = mem_ready;
      end
      StExec: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      StAluWb: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      StBranch: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch_int = 1'b1;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StAddiWb: begin
        regwrite = 1'b1;
      end
      StJump: begin
        pcsrc       = 2'b10;
        pcwrite_int = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      StBne: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        bne_int = 1'b1;
      end
`endif
      default: ;
    endcase

    pcen       = pcwrite_int | (branch_int & zero) | (bne_int & ~zero);
    illegal_op = illegal_int;
    state_o    = STATE_W'(state_q);

    if (reset) begin
      iord       = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      pcen       = 1'b0;
      illegal_op = 1'b0;
      state_o    = '0;
    end
  end

endmodule

// File: tb/tb_mc_main_ctrl_fsm.sv
// Bench for mc_main_ctrl_fsm: instruction-level model checked every cycle plus directed pins.
module tb_mc_main_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'b000000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, illegal_op;
  logic [3:0] state_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mc_main_ctrl_fsm #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: an instruction is a class plus a step index into that class's state walk.
  localparam int CNone = 0, CLw = 1, CSw = 2, CR = 3, CBeq = 4, CAddi = 5, CJ = 6, CBne = 7;
  int seq_tbl [8][5];
  int seq_len [8];
  int m_cls = CNone;
  int m_step = 0;

  function automatic int op_class(input logic [5:0] o);
    case (o)
      6'b100011: return CLw;
      6'b101011: return CSw;
      6'b000000: return CR;
      6'b000100: return CBeq;
      6'b001000: return CAddi;
      6'b000010: return CJ;
`ifdef MC_CTRL_BNE_EN
      6'b000101: return CBne;
`endif
      default:   return CNone;
    endcase
  endfunction

  function automatic int model_state();
    if (m_step < 2) return m_step;
    return seq_tbl[m_cls][m_step];
  endfunction

  function automatic logic [13:0] exp_ctrl(input int s, input logic mr, input logic z,
                                           input logic rst);
    logic io = 0, ir = 0, mw = 0, rw = 0, rd = 0, mt = 0, sa = 0, pe = 0;
    logic [1:0] sb = 0, ao = 0, ps = 0;
    case (s)
      0:  begin sb = 2'b01; ir = mr; pe = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin rw = 1; mt = 1; end
      5:  begin io = 1; mw = mr; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      12: begin sa = 1; ao = 2'b01; ps = 2'b01; pe = ~z; end
      default: ;
    endcase
    if (rst) return 14'd0;
    return {io, ir, mw, rw, rd, mt, sa, sb, ao, ps, pe};
  endfunction

  int ms;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_step <= 0;
      m_cls  <= CNone;
    end else begin
      ms = model_state();
      if ((ms == 0 || ms == 3 || ms == 5) && !mem_ready) begin
        m_step <= m_step;
      end else if (m_step == 0) begin
        m_step <= 1;
      end else if (m_step == 1) begin
        if (op_class(op) == CNone) begin
          m_step <= 0;
        end else begin
          m_cls  <= op_class(op);
          m_step <= 2;
        end
      end else if (m_step + 1 >= seq_len[m_cls]) begin
        m_step <= 0;
      end else begin
        m_step <= m_step + 1;
      end
    end
  end

  int cs;

  always @(negedge clk) begin
    cs = model_state();
    check("state", state_o, reset ? 0 : cs);
    check("ctrl", {iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                   alusrcb, aluop, pcsrc, pcen}, exp_ctrl(cs, mem_ready, zero, reset));
    check("illegal_op", illegal_op, (!reset && cs == 1 && op_class(op) == CNone) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    seq_tbl[CNone] = '{0, 1, 0, 0, 0};
    seq_tbl[CLw]   = '{0, 1, 2, 3, 4};
    seq_tbl[CSw]   = '{0, 1, 2, 5, 0};
    seq_tbl[CR]    = '{0, 1, 6, 7, 0};
    seq_tbl[CBeq]  = '{0, 1, 8, 0, 0};
    seq_tbl[CAddi] = '{0, 1, 9, 10, 0};
    seq_tbl[CJ]    = '{0, 1, 11, 0, 0};
    seq_tbl[CBne]  = '{0, 1, 12, 0, 0};
    seq_len = '{2, 5, 4, 4, 3, 4, 3, 3};

    #2 reset = 1'b1;
    #1;
    check("rst_state", state_o, 0);
    check("rst_irwrite", irwrite, 0);
    check("rst_alusrcb", alusrcb, 0);
    check("rst_pcen", pcen, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rel_state", state_o, 0);
    check("rel_alusrcb", alusrcb, 2'b01);
    check("rel_irwrite", irwrite, 1);

    // add
    op = 6'b000000;
    tick(); check("add_s1", state_o, 1);
    tick(); check("add_s6", state_o, 6); check("add_exec_rw", regwrite, 0);
    tick(); check("add_s7", state_o, 7); check("add_wb_rw", regwrite, 1);
    check("add_wb_rd", regdst, 1);
    tick(); check("add_s0", state_o, 0);

    // reset in the middle of EXEC
    tick(); tick(); check("abort_s6", state_o, 6);
    reset = 1'b1;
    #1;
    check("abort_state", state_o, 0);
    check("abort_irwrite", irwrite, 0);
    check("abort_regwrite", regwrite, 0);
    check("abort_aluop", aluop, 0);
    tick();
    reset = 1'b0;
    #1;
    check("abort_rel_state", state_o, 0);
    check("abort_rel_alusrcb", alusrcb, 2'b01);
    check("abort_rel_irwrite", irwrite, 1);

    // lw with three stalled cycles in MEMRD
    op = 6'b100011;
    tick(); tick(); tick(); check("lw_s3", state_o, 3);
    mem_ready = 1'b0;
    #1; check("lw_iord", iord, 1);
    tick(); check("lw_hold1", state_o, 3);
    tick(); check("lw_hold2", state_o, 3);
    tick(); check("lw_hold3", state_o, 3);
    mem_ready = 1'b1;
    tick(); check("lw_s4", state_o, 4); check("lw_memtoreg", memtoreg, 1);
    check("lw_rw", regwrite, 1);
    tick(); check("lw_s0", state_o, 0);

    // sw with a FETCH stall and mem_ready low during DECODE (ignored there)
    op = 6'b101011;
    mem_ready = 1'b0;
    #1; check("sw_fetch_irwrite", irwrite, 0);
    tick(); check("sw_fetch_hold", state_o, 0);
    mem_ready = 1'b1;
    tick(); check("sw_s1", state_o, 1);
    mem_ready = 1'b0;
    tick(); check("sw_s2", state_o, 2);
    tick(); check("sw_s5", state_o, 5); check("sw_memwrite_lo", memwrite, 0);
    mem_ready = 1'b1;
    #1; check("sw_memwrite_hi", memwrite, 1);
    tick(); check("sw_s0", state_o, 0);

    // beq taken and not taken
    op = 6'b000100; zero = 1'b1;
    tick(); tick(); check("beq_s8", state_o, 8); check("beq_pcen1", pcen, 1);
    check("beq_pcsrc", pcsrc, 2'b01);
    tick();
    zero = 1'b0;
    tick(); tick(); check("beq_nt_pcen", pcen, 0);
    tick();

    // addi
    op = 6'b001000;
    tick(); tick(); check("addi_s9", state_o, 9);
    tick(); check("addi_s10", state_o, 10); check("addi_rw", regwrite, 1);
    check("addi_rd", regdst, 0);
    tick();

    // j
    op = 6'b000010;
    tick(); tick(); check("j_s11", state_o, 11); check("j_pcen", pcen, 1);
    check("j_pcsrc", pcsrc, 2'b10);
    tick(); check("j_s0", state_o, 0);

    // unsupported opcode
    op = 6'b111111;
    tick(); check("ill_pulse", illegal_op, 1); check("ill_rw", regwrite, 0);
    tick(); check("ill_s0", state_o, 0); check("ill_clear", illegal_op, 0);

    // bne opcode
    op = 6'b000101; zero = 1'b0;
    tick();
`ifdef MC_CTRL_BNE_EN
    check("bne_no_ill", illegal_op, 0);
    tick(); check("bne_s12", state_o, 12); check("bne_pcen", pcen, 1);
    tick();
`else
    check("bne_ill", illegal_op, 1);
    tick(); check("bne_s0", state_o, 0);
`endif

    op = 6'b000000;
    repeat (6) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
